// File: rtl/rng_pack_fifo_pkg.sv
// Shared constants and types for the byte-packing RNG FIFO.
// Holds the FIFO word width together with the byte-lane geometry used by the packer.
package rng_pack_fifo_pkg;

    localparam int FIFO_DATA_W    = 32;
    localparam int FIFO_DEPTH_DEF = 512;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef logic [BYTE_W-1:0]      byte_t;
    typedef logic [FIFO_DATA_W-1:0] word_t;
    typedef logic [BCNT_W-1:0]      bcnt_t;

    // First byte lands in the most significant lane.
    function automatic word_t pack_word(input byte_t b0, input byte_t b1,
                                       input byte_t b2, input byte_t b3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/rng_pack_fifo_if.sv
// Byte-write / word-read handshake bundle for rng_pack_fifo.
// DEPTH must match the FIFO instance so COUNT has the right width.
interface rng_pack_fifo_if #(
    parameter int DEPTH = 512
);
    import rng_pack_fifo_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    byte_t         DATA_W;
    logic          WE;
    word_t         DATA_R;
    logic          RE;
    logic          EMPTY;
    logic          FULL;
    logic          SOFT_RST;
    logic [CW-1:0] COUNT;
    bcnt_t         BYTE_CNT;

    modport master (
        output DATA_W, WE, RE, SOFT_RST,
        input  DATA_R, EMPTY, FULL, COUNT, BYTE_CNT
    );

    modport slave (
        input  DATA_W, WE, RE, SOFT_RST,
        output DATA_R, EMPTY, FULL, COUNT, BYTE_CNT
    );

endinterface

// File: rtl/rng_pack_fifo_byte_packer.sv
// Collects accepted bytes into a big-endian 32-bit word and strobes completion
// on the edge that takes the final byte; the final byte bypasses the lane registers.
module rng_byte_packer
    import rng_pack_fifo_pkg::*;
(
    input  logic  CLK,
    input  logic  RST_N,
    input  logic  soft_rst,
    input  logic  wr_en,
    input  byte_t byte_in,
    output bcnt_t byte_cnt,
    output logic  word_done,
    output word_t word
);

    localparam int LANES = BYTES_PER_WORD - 1;

    bcnt_t             byte_cnt_q, byte_cnt_d;
    byte_t [LANES-1:0] lane_q, lane_d;
    logic              take;

    assign take = wr_en && !soft_rst;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        lane_d     = lane_q;
        if (soft_rst) begin
            byte_cnt_d = '0;
        end else if (wr_en) begin
            byte_cnt_d = byte_cnt_q + bcnt_t'(1);
        end
        for (int i = 0; i < LANES; i++) begin
            if (take && byte_cnt_q == bcnt_t'(i)) begin
                lane_d[i] = byte_in;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byte_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Lane data is qualified by byte_cnt, so it carries no reset.
    always_ff @(posedge CLK) begin
        lane_q <= lane_d;
    end

    assign byte_cnt  = byte_cnt_q;
    assign word_done = take && (byte_cnt_q == bcnt_t'(BYTES_PER_WORD - 1));
    assign word      = pack_word(lane_q[0], lane_q[1], lane_q[2], byte_in);

endmodule

// File: rtl/rng_pack_fifo.sv
// Byte-in / word-out FWFT FIFO: bytes are packed into 32-bit words which are
// queued in a DEPTH-entry circular buffer with a combinational head read.
module rng_pack_fifo
    import rng_pack_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic            CLK,
    input  logic            RST_N,
    rng_pack_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rng_pack_fifo: DEPTH must be a power of two and at least 4");
    end

    word_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    bcnt_t byte_cnt;
    word_t word;
    logic  word_done;
    logic  full, empty, wr_en, pop;

    // FULL only blocks the byte that would complete a word into a full store.
    assign full  = (count_q == CW'(DEPTH)) && (byte_cnt == bcnt_t'(BYTES_PER_WORD - 1));
    assign empty = (count_q == '0);
    assign wr_en = bus.WE && !full;
    assign pop   = bus.RE && !empty && !bus.SOFT_RST;

    rng_byte_packer u_packer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .soft_rst  (bus.SOFT_RST),
        .wr_en     (wr_en),
        .byte_in   (bus.DATA_W),
        .byte_cnt  (byte_cnt),
        .word_done (word_done),
        .word      (word)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.SOFT_RST) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (word_done) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)       rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({word_done, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // word_done can never fire into a full store, so no overwrite guard is needed.
    always_ff @(posedge CLK) begin
        if (word_done) begin
            mem[wr_ptr_q] <= word;
        end
    end

    assign bus.DATA_R   = mem[rd_ptr_q];
    assign bus.EMPTY    = empty;
    assign bus.FULL     = full;
    assign bus.COUNT    = count_q;
    assign bus.BYTE_CNT = byte_cnt;

endmodule

// File: tb/tb_rng_pack_fifo.sv
// Directed bench for rng_pack_fifo: a vector table for ordering, full and
// simultaneous-event behaviour, then hand sequences for wrap, soft and async reset.
module tb_rng_pack_fifo;
    import rng_pack_fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4_n, rst8_n;

    rng_pack_fifo_if #(.DEPTH(4)) bus4 ();
    rng_pack_fifo_if #(.DEPTH(8)) bus8 ();

    rng_pack_fifo #(.DEPTH(4)) dut4 (.CLK(clk), .RST_N(rst4_n), .bus(bus4));
    rng_pack_fifo #(.DEPTH(8)) dut8 (.CLK(clk), .RST_N(rst8_n), .bus(bus8));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [7:0]  d;
        logic        re;
        logic        sr;
        logic        e;
        logic        f;
        int          cnt;
        int          bc;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [7:0] d, input logic re,
                                input logic sr, input logic e, input logic f,
                                input int cnt, input int bc, input logic [31:0] data);
        vec_t v;
        v.we = we; v.d = d; v.re = re; v.sr = sr;
        v.e = e; v.f = f; v.cnt = cnt; v.bc = bc; v.data = data;
        tbl.push_back(v);
    endfunction

    task automatic step4(input logic we, input logic [7:0] d, input logic re, input logic sr);
        bus4.WE = we; bus4.DATA_W = d; bus4.RE = re; bus4.SOFT_RST = sr;
        @(posedge clk); #1;
    endtask

    task automatic step8(input logic we, input logic [7:0] d, input logic re);
        bus8.WE = we; bus8.DATA_W = d; bus8.RE = re; bus8.SOFT_RST = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk4(input string tag, input logic e, input logic f,
                        input int cnt, input int bc, input logic [31:0] data);
        chk({tag, "_empty"}, 32'(bus4.EMPTY), 32'(e));
        chk({tag, "_full"},  32'(bus4.FULL),  32'(f));
        chk({tag, "_count"}, 32'(bus4.COUNT), 32'(cnt));
        chk({tag, "_bcnt"},  32'(bus4.BYTE_CNT), 32'(bc));
        if (!e) chk({tag, "_data"}, bus4.DATA_R, data);
    endtask

    task automatic chk8(input string tag, input logic e, input int cnt, input int bc);
        chk({tag, "_empty"}, 32'(bus8.EMPTY), 32'(e));
        chk({tag, "_full"},  32'(bus8.FULL),  32'(0));
        chk({tag, "_count"}, 32'(bus8.COUNT), 32'(cnt));
        chk({tag, "_bcnt"},  32'(bus8.BYTE_CNT), 32'(bc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] q[$];
        int          nread;
        int          cyc;
        logic        re;

        // byte order
        add(1, 8'h12, 0, 0, 1, 0, 0, 1, '0);
        add(1, 8'h34, 0, 0, 1, 0, 0, 2, '0);
        add(1, 8'h56, 0, 0, 1, 0, 0, 3, '0);
        add(1, 8'h78, 0, 0, 0, 0, 1, 0, 32'h12345678);
        add(0, 8'h00, 1, 0, 1, 0, 0, 0, '0);
        // fill all four words
        for (int i = 0; i < 16; i++)
            add(1, 8'hA0 + 8'(i), 0, 0, ((i + 1) / 4) == 0, 0, (i + 1) / 4, (i + 1) % 4,
                32'hA0A1A2A3);
        add(1, 8'hB0, 0, 0, 0, 0, 4, 1, 32'hA0A1A2A3);
        add(1, 8'hB1, 0, 0, 0, 0, 4, 2, 32'hA0A1A2A3);
        add(1, 8'hB2, 0, 0, 0, 1, 4, 3, 32'hA0A1A2A3);
        add(1, 8'hAA, 0, 0, 0, 1, 4, 3, 32'hA0A1A2A3);  // dropped
        add(0, 8'h00, 1, 0, 0, 0, 3, 3, 32'hA4A5A6A7);
        add(1, 8'hAA, 0, 0, 0, 0, 4, 0, 32'hA4A5A6A7);
        add(0, 8'h00, 1, 0, 0, 0, 3, 0, 32'hA8A9AAAB);
        add(0, 8'h00, 1, 0, 0, 0, 2, 0, 32'hACADAEAF);
        // simultaneous pop and completion
        add(1, 8'h11, 0, 0, 0, 0, 2, 1, 32'hACADAEAF);
        add(1, 8'h22, 0, 0, 0, 0, 2, 2, 32'hACADAEAF);
        add(1, 8'h33, 0, 0, 0, 0, 2, 3, 32'hACADAEAF);
        add(1, 8'h9C, 1, 0, 0, 0, 2, 0, 32'hB0B1B2AA);
        add(0, 8'h00, 1, 0, 0, 0, 1, 0, 32'h1122339C);
        add(0, 8'h00, 1, 0, 1, 0, 0, 0, '0);
        add(0, 8'h00, 1, 0, 1, 0, 0, 0, '0);            // pop on empty ignored

        rst4_n = 1'b0; rst8_n = 1'b0;
        bus4.WE = 0; bus4.RE = 0; bus4.SOFT_RST = 0; bus4.DATA_W = '0;
        bus8.WE = 0; bus8.RE = 0; bus8.SOFT_RST = 0; bus8.DATA_W = '0;
        repeat (2) @(posedge clk);
        #1;
        chk4("reset", 1, 0, 0, 0, '0);
        rst4_n = 1'b1; rst8_n = 1'b1;

        foreach (tbl[i]) begin
            step4(tbl[i].we, tbl[i].d, tbl[i].re, tbl[i].sr);
            chk4($sformatf("vec%0d", i), tbl[i].e, tbl[i].f, tbl[i].cnt, tbl[i].bc, tbl[i].data);
        end

        // wrap-around: 40 words, pop every third cycle when something is queued
        nread = 0; cyc = 0;
        for (int k = 0; k < 40; k++) begin
            for (int b = 0; b < 4; b++) begin
                re = (cyc % 3 == 0) && (q.size() > 0);
                bus4.WE = 1'b1; bus4.DATA_W = (b == 3) ? 8'(k) : 8'h00; bus4.RE = re;
                @(negedge clk);
                chk("wrap_empty", 32'(bus4.EMPTY), 32'(q.size() == 0));
                if (re) chk("wrap_data", bus4.DATA_R, q[0]);
                @(posedge clk); #1;
                if (re) begin void'(q.pop_front()); nread++; end
                if (b == 3) q.push_back(32'(k));
                cyc++;
            end
        end
        bus4.WE = 1'b0;
        for (int n = 0; n < 8 && q.size() > 0; n++) begin
            bus4.RE = 1'b1;
            @(negedge clk);
            chk("wrap_drain_data", bus4.DATA_R, q[0]);
            @(posedge clk); #1;
            void'(q.pop_front()); nread++;
        end
        bus4.RE = 1'b0;
        chk("wrap_nread", 32'(nread), 32'd40);
        chk4("wrap_end", 1, 0, 0, 0, '0);

        // soft reset mid-word
        for (int i = 0; i < 14; i++) step4(1, 8'h50 + 8'(i), 0, 0);
        chk4("sr_pre", 0, 0, 3, 2, 32'h50515253);
        step4(1, 8'hFF, 0, 1);
        chk4("sr_clr", 1, 0, 0, 0, '0);
        step4(1, 8'hDE, 0, 0);
        step4(1, 8'hAD, 0, 0);
        step4(1, 8'hBE, 0, 0);
        step4(1, 8'hEF, 0, 0);
        chk4("sr_word", 0, 0, 1, 0, 32'hDEADBEEF);
        step4(0, 8'h00, 1, 0);
        chk4("sr_pop", 1, 0, 0, 0, '0);
        bus4.RE = 1'b0;

        // async reset between edges with five words and one partial byte held
        for (int i = 0; i < 21; i++) step8(1, 8'h60 + 8'(i), 0);
        chk8("ar_pre", 0, 5, 1);
        bus8.WE = 1'b0; bus8.RE = 1'b1;
        rst8_n = 1'b0;
        #2;
        chk8("ar_async", 1, 0, 0);
        @(posedge clk); #1;
        chk8("ar_hold", 1, 0, 0);
        rst8_n = 1'b1;
        step8(1, 8'h01, 0);
        chk8("ar_first", 1, 0, 1);
        step8(1, 8'h02, 0);
        step8(1, 8'h03, 0);
        step8(1, 8'h04, 0);
        chk8("ar_word", 0, 1, 0);
        chk("ar_data", bus8.DATA_R, 32'h01020304);
        bus8.WE = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rng_pack_fifo.md
RNG_PACK_FIFO -- requirements
Module: rng_pack_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512, number of 32-bit words stored; power of two, at least 4.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port DATA_W  input  8  write byte.
REQ-005 SHALL have port WE  input  1  byte write request.
REQ-006 SHALL have port DATA_R  output  32  head word, first-word-fall-through.
REQ-007 SHALL have port RE  input  1  word read (pop) request.
REQ-008 SHALL have port EMPTY  output  1  no complete word stored.
REQ-009 SHALL have port FULL  output  1  next byte write would be refused.
REQ-010 SHALL have port SOFT_RST  input  1  synchronous clear of all contents.
REQ-011 SHALL have port COUNT  output  log2(DEPTH)+1  complete words stored.
REQ-012 SHALL have port BYTE_CNT  output  2  bytes held in the partial word (0-3).

Function
REQ-013 SHALL pack bytes big-endian: 1st accepted byte -> word[31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-014 SHALL accept a byte when WE=1 and FULL=0, and increment BYTE_CNT mod 4.
REQ-015 SHALL, on the accepted 4th byte, write the assembled word to storage in that same edge, with COUNT incremented and BYTE_CNT 0 after the edge.
REQ-016 SHALL drive FULL = (COUNT==DEPTH) AND (BYTE_CNT==3); bytes 1-3 of a word are accepted even when storage is full.
REQ-017 SHALL ignore WE while FULL=1: the byte is dropped and the packer state is unchanged.
REQ-018 SHALL drive EMPTY = (COUNT==0); bytes in the partial word do not clear EMPTY.
REQ-019 SHALL present the oldest word on DATA_R combinationally while EMPTY=0; DATA_R is don't-care while EMPTY=1.
REQ-020 SHALL pop the head word on a rising edge where RE=1 and EMPTY=0; RE while EMPTY=1 is ignored.
REQ-021 SHALL, on a simultaneous pop and word completion, perform both, leaving COUNT unchanged; FULL is evaluated on pre-edge state, with no same-cycle bypass.
REQ-022 SHALL wrap read/write pointers modulo DEPTH with no gap or duplication.
REQ-023 SHALL, when SOFT_RST=1 at an edge, set COUNT, BYTE_CNT and both pointers to 0 and discard WE/RE in that cycle; SOFT_RST has priority.
REQ-024 SHALL have zero-cycle read latency: a completed word is visible on DATA_R and EMPTY falls in the cycle after the completing edge.

Reset
REQ-025 SHALL, while RST_N=0, asynchronously force pointers, COUNT and BYTE_CNT to 0, giving EMPTY=1 and FULL=0.
REQ-026 SHALL leave the storage array and packer byte registers uninitialised by reset.
REQ-027 SHALL release reset synchronously to CLK; the first accepted write is at the first edge with RST_N=1.
REQ-028 SHALL, on reset assertion mid-word, discard the partial word; the next byte becomes [31:24].

Structure
REQ-029 SHALL place the byte-lane constants (bytes per word = 4, byte width = 8) in the shared rng package, alongside the existing FIFO width constants.
REQ-030 SHALL implement the packer (byte registers, BYTE_CNT, completion strobe) as sub-module rng_byte_packer; word storage and pointers stay in rng_pack_fifo.

Verification
REQ-031 SHALL cover byte order: write 0x12,0x34,0x56,0x78 -> EMPTY=0 next cycle, DATA_R=0x12345678, COUNT=1, BYTE_CNT=0.
REQ-032 SHALL cover the full boundary: DEPTH=4; write 16 bytes, then 3 more (BYTE_CNT=3) -> FULL=1; a further byte 0xAA is dropped; pop -> FULL=0; 0xAA is then accepted and completes a word.
REQ-033 SHALL cover simultaneous events: COUNT=2, BYTE_CNT=3, RE=1 with WE=1 (byte 0x9C) -> COUNT stays 2, head advances, new tail ends in 0x9C.
REQ-034 SHALL cover wrap-around: DEPTH=4; stream 40 words 0x00000000..0x00000027 with interleaved pops -> every word is read back once, in order.
REQ-035 SHALL cover SOFT_RST mid-word: BYTE_CNT=2, COUNT=3, SOFT_RST=1 with WE=1 -> COUNT=0, BYTE_CNT=0, EMPTY=1; the next 4 bytes form exactly one word.
REQ-036 SHALL cover async reset: RST_N low between edges with COUNT=5 -> EMPTY=1 and COUNT=0 before the next edge; RE is ignored.
